ammrv_mem_slave: RTL
====================

Name: ammrv_mem_slave

Overview:
Avalon-MM responder (slave endpoint) that terminates the 32-bit Avalon-MM command stream issued by masters and retiming stages.
- Backs the bus with a DEPTH-word internal memory.
- Inserts a programmable number of wait states per command.
- Returns read data with a fixed, pipelined read latency via readdatavalid.
- Used as the bus sink in subsystem benches and as a small scratchpad RAM in real designs.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 2..65536
WAIT_STATES, 0, cycles s_waitrequest is held high per command before acceptance (0..15)
READ_LATENCY, 1, cycles from read acceptance to s_readdatavalid (1..8)

Ports:
clk  in  1  clock, all logic on rising edge
areset_n  in  1  asynchronous active-low reset
s_address  in  32  byte address; bits [1:0] ignored
s_byteenable  in  4  write byte lanes
s_writedata  in  32  write data
s_read  in  1  read request
s_write  in  1  write request
s_waitrequest  out  1  stall; a command is accepted in a cycle where it is present and this is 0
s_readdata  out  32  read data, valid only with s_readdatavalid
s_readdatavalid  out  1  one-cycle pulse per accepted read

Behaviour:
- Reset (areset_n=0, asynchronous):
  - s_waitrequest=1, s_readdatavalid=0, s_readdata=0.
  - Wait counter = 0; all read-pipeline valid bits cleared.
  - Memory contents are not reset.
- Word index = s_address[2+log2(DEPTH)-1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4 bytes.
- Wait counter wcnt (4 bits):
  - Cleared when no command is present, or in the cycle a command is accepted.
  - Otherwise increments while a command is present.
- s_waitrequest:
  - With a command present: s_waitrequest = (wcnt != WAIT_STATES).
  - With no command present: 0. This value is don't-care to masters but is fixed for checking.
  - Out of reset the combinational path applies; during reset it is forced to 1.
- Acceptance cycle = (s_read|s_write) & ~s_waitrequest.
  - WAIT_STATES=0 gives zero-wait, one command accepted per cycle.
  - WAIT_STATES=N gives acceptance on the (N+1)th cycle the command is held.
- Write: in the acceptance cycle, each byte lane i with s_byteenable[i]=1 updates mem[idx][8i+7:8i]. Other lanes are unchanged. byteenable=0 produces no change and still completes.
- Read:
  - In the acceptance cycle, mem[idx] is captured into stage 1 of the read pipeline.
  - s_readdatavalid pulses exactly READ_LATENCY cycles after the acceptance edge, carrying that data.
  - The pipeline is fully pipelined: back-to-back reads return back-to-back valids, in order, with no bubbles.
- s_readdata = 0 whenever s_readdatavalid = 0.
- A read accepted the cycle after a write to the same word returns the new data (no stale read).
- s_read and s_write both high (protocol violation): treated as a write only. No readdatavalid is generated.
- Command withdrawn while stalled (violation): wcnt clears and nothing is executed.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid is emitted after release. A write accepted before reset assertion remains in memory.
- Exactly one command is executed per acceptance; there is no internal queueing beyond the read pipeline.

Decomposition:
- Shared package ammrv_pkg (extend if present):
  - AMM_AW=32, AMM_DW=32, AMM_BEW=4.
  - Function clog2 for the index width.
- One sub-module, ammrv_rd_pipe: parameterised LAT-stage valid/data delay line with async active-low clear. Instantiated with LAT=READ_LATENCY.
- The memory array and the wait-state logic stay in the top level.

Test Plan:
1. Hold areset_n=0 with s_read=1 -> s_waitrequest=1, s_readdatavalid=0, s_readdata=0. Release -> first read accepted per WAIT_STATES timing.
2. Defaults (WS=0, RL=1): write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> accepted with no stall; valid one cycle after acceptance with data 0xDEADBEEF.
3. Write 0x11223344 to 0x20, then write 0x0000AA00 with be=4'b0010, then read -> 0x1122AA44. With be=4'b0000 write of 0xFFFFFFFF, a re-read still returns 0x1122AA44.
4. WS=2, RL=3: hold read of 0x10 -> s_waitrequest high 2 cycles, low on the 3rd; readdatavalid exactly 3 cycles after acceptance. Aliasing check with DEPTH=256: write 0x400 then read 0x000 -> same data.
5. RL=3, WS=0: reads of 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four consecutive valid pulses in order. Also: write then immediate read of the same word -> new data returned.
6. Reads in flight at RL=4: pulse areset_n low for one cycle -> no readdatavalid afterwards. s_read=s_write=1 -> write performed, no readdatavalid.

Source files
------------

// File: rtl/ammrv_pkg.sv
// Shared Avalon-MM bus widths and elaboration-time helpers for the ammrv blocks.
package ammrv_pkg;

  localparam int AMM_AW  = 32;
  localparam int AMM_DW  = 32;
  localparam int AMM_BEW = 4;

  // Smallest r with 2**r >= value; used to size the word index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ammrv_rd_pipe.sv
// LAT-stage valid/data delay line carrying read results to the bus.
// Output data is forced to zero whenever the output valid is low.
module ammrv_rd_pipe
  import ammrv_pkg::*;
#(
  parameter int LAT = 1,
  parameter int DW  = AMM_DW
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [LAT-1:0] r_valid;
  logic [DW-1:0]  r_data [LAT];

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_valid <= '0;
      for (int i = 0; i < LAT; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[LAT-1];
  assign o_data  = r_valid[LAT-1] ? r_data[LAT-1] : '0;

endmodule

// File: rtl/ammrv_mem_slave.sv
// Avalon-MM responder backed by a DEPTH-word memory, with programmable
// wait states per command and a fixed pipelined read latency.
module ammrv_mem_slave
  import ammrv_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int WAIT_STATES  = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               areset_n,
  input  logic [AMM_AW-1:0]  s_address,
  input  logic [AMM_BEW-1:0] s_byteenable,
  input  logic [AMM_DW-1:0]  s_writedata,
  input  logic               s_read,
  input  logic               s_write,
  output logic               s_waitrequest,
  output logic [AMM_DW-1:0]  s_readdata,
  output logic               s_readdatavalid
);

  localparam int         IW = clog2(DEPTH);
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  logic [AMM_DW-1:0] r_mem [DEPTH];
  logic [3:0]        r_wcnt;

  logic              w_cmd;
  logic              w_accept;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [IW-1:0]     w_idx;
  logic [AMM_DW-1:0] w_rd_word;
  logic              w_addr_unused;

  // Upper address bits alias; byte-offset bits are ignored.
  assign w_idx         = s_address[IW+1:2];
  assign w_addr_unused = ^{s_address[AMM_AW-1:IW+2], s_address[1:0]};

  assign w_cmd         = s_read | s_write;
  assign s_waitrequest = ~areset_n | (w_cmd & (r_wcnt != WS));
  assign w_accept      = w_cmd & ~s_waitrequest;
  // A simultaneous read+write is executed as a write only.
  assign w_wr_acc      = w_accept & s_write;
  assign w_rd_acc      = w_accept & s_read & ~s_write;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_wcnt <= '0;
    end else if (!w_cmd || w_accept) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  // Memory contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < AMM_BEW; i++) begin
        if (s_byteenable[i]) r_mem[w_idx][8*i +: 8] <= s_writedata[8*i +: 8];
      end
    end
  end

  assign w_rd_word = r_mem[w_idx];

  ammrv_rd_pipe #(
    .LAT (READ_LATENCY),
    .DW  (AMM_DW)
  ) u_rd_pipe (
    .clk      (clk),
    .areset_n (areset_n),
    .i_valid  (w_rd_acc),
    .i_data   (w_rd_word),
    .o_valid  (s_readdatavalid),
    .o_data   (s_readdata)
  );

endmodule
